// File: rtl/vram_wr_arb_if.sv
// Bundle of the vram_wr_arb ports: clear control, two write requesters, and the VRAM write port.
interface vram_wr_arb_if;
  logic       clr_start;
  logic [7:0] clr_char;
  logic       clr_busy;
  logic       clr_done;
  logic       req0_valid;
  logic [9:0] req0_addr;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [9:0] req1_addr;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic [9:0] v_ada;
  logic [7:0] v_din;
  logic       v_cea;
  logic       v_reseta;
  logic       v_resetb;
  logic       v_ceb;
  logic       v_oce;

  modport master (
    output clr_start, clr_char, req0_valid, req0_addr, req0_data,
           req1_valid, req1_addr, req1_data,
    input  clr_busy, clr_done, req0_ready, req1_ready,
           v_ada, v_din, v_cea, v_reseta, v_resetb, v_ceb, v_oce
  );

  modport slave (
    input  clr_start, clr_char, req0_valid, req0_addr, req0_data,
           req1_valid, req1_addr, req1_data,
    output clr_busy, clr_done, req0_ready, req1_ready,
           v_ada, v_din, v_cea, v_reseta, v_resetb, v_ceb, v_oce
  );
endinterface

// File: rtl/vram_wr_arb.sv
// Text-VRAM write arbiter: full-memory clear engine plus round-robin merge of two
// write requesters onto one registered VRAM write port.
module vram_wr_arb #(
  parameter logic [7:0] INIT_CHAR = 8'h20,
  parameter int         DEPTH     = 1024
) (
  input logic          MEMORY_CLK,
  input logic          rst_n,
  vram_wr_arb_if.slave bus
);
  localparam logic [0:0] ST_CLEAR  = 1'b0;
  localparam logic [0:0] ST_SERVE  = 1'b1;
  localparam logic [9:0] LAST_ADDR = 10'(DEPTH - 1);

  logic [0:0] state_q, state_d;
  logic [9:0] cnt_q, cnt_d;
  logic [7:0] fill_q, fill_d;
  logic       last_grant_q, last_grant_d;
  logic [9:0] v_ada_q, v_ada_d;
  logic [7:0] v_din_q, v_din_d;
  logic       v_cea_q, v_cea_d;
  logic       clr_done_q, clr_done_d;
  logic       grant0, grant1;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fill_d       = fill_q;
    last_grant_d = last_grant_q;
    v_ada_d      = v_ada_q;
    v_din_d      = v_din_q;
    v_cea_d      = 1'b0;
    clr_done_d   = 1'b0;
    grant0       = 1'b0;
    grant1       = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        // Stay in CLEAR through the cycle that shows the final write so busy
        // covers clr_done and drops on the following edge.
        if (clr_done_q) begin
          state_d = ST_SERVE;
        end else begin
          v_cea_d    = 1'b1;
          v_ada_d    = cnt_q;
          v_din_d    = fill_q;
          clr_done_d = (cnt_q == LAST_ADDR);
          if (cnt_q != LAST_ADDR) cnt_d = cnt_q + 10'd1;
        end
      end
      default: begin
        if (bus.clr_start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
          fill_d  = bus.clr_char;
        end else begin
          // On a tie, the requester that did not win last time goes first.
          grant0 = bus.req0_valid & (~bus.req1_valid | last_grant_q);
          grant1 = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);
          if (grant0) begin
            v_cea_d      = 1'b1;
            v_ada_d      = bus.req0_addr;
            v_din_d      = bus.req0_data;
            last_grant_d = 1'b0;
          end else if (grant1) begin
            v_cea_d      = 1'b1;
            v_ada_d      = bus.req1_addr;
            v_din_d      = bus.req1_data;
            last_grant_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge MEMORY_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_CLEAR;
      cnt_q        <= '0;
      fill_q       <= INIT_CHAR;
      last_grant_q <= 1'b1;
      v_ada_q      <= '0;
      v_din_q      <= '0;
      v_cea_q      <= 1'b0;
      clr_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fill_q       <= fill_d;
      last_grant_q <= last_grant_d;
      v_ada_q      <= v_ada_d;
      v_din_q      <= v_din_d;
      v_cea_q      <= v_cea_d;
      clr_done_q   <= clr_done_d;
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.clr_busy   = (state_q == ST_CLEAR);
  assign bus.clr_done   = clr_done_q;
  assign bus.v_ada      = v_ada_q;
  assign bus.v_din      = v_din_q;
  assign bus.v_cea      = v_cea_q;
  assign bus.v_reseta   = 1'b0;
  assign bus.v_resetb   = 1'b0;
  assign bus.v_ceb      = 1'b1;
  assign bus.v_oce      = 1'b1;
endmodule

// File: tb/tb_vram_wr_arb.sv
// Bench for vram_wr_arb: scoreboard of expected VRAM writes plus a table of arbitration steps.
module tb_vram_wr_arb;
  logic clk = 1'b0;
  logic rst_n;
  vram_wr_arb_if bus();

  vram_wr_arb #(.INIT_CHAR(8'h20), .DEPTH(1024)) dut (
    .MEMORY_CLK(clk),
    .rst_n     (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] addr;
    logic [7:0] data;
    logic       done;
  } wr_t;

  typedef struct {
    logic       v0;
    logic [9:0] a0;
    logic [7:0] d0;
    logic       v1;
    logic [9:0] a1;
    logic [7:0] d1;
    logic       r0;
    logic       r1;
  } vec_t;

  wr_t  sb[$];
  vec_t tbl[10];
  int   errs   = 0;
  int   checks = 0;
  logic prev_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_clear(input logic [7:0] ch);
    for (int i = 0; i < 1024; i++) sb.push_back('{10'(i), ch, (i == 1023)});
  endtask

  task automatic wait_clear();
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk); #1;
      if (!bus.clr_busy) break;
    end
    chk("clear_finished", 32'(bus.clr_busy), 32'd0);
    chk("clear_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_addr(input logic [9:0] a);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk); #1;
      if (bus.v_cea && bus.v_ada == a) begin
        ok = 1'b1;
        break;
      end
    end
    chk("reach_addr", 32'(ok), 32'd1);
  endtask

  // Write-port monitor: every write must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready_excl", 32'((bus.req0_ready & bus.req1_ready) |
                            (bus.clr_busy & (bus.req0_ready | bus.req1_ready))), 32'd0);
      if (prev_done) chk("busy_after_done", 32'(bus.clr_busy), 32'd0);
      if (bus.v_cea) begin
        if (sb.size() == 0) begin
          chk("unexpected_write", 32'(bus.v_ada), 32'h7fff);
        end else begin
          wr_t e;
          e = sb.pop_front();
          chk("wr_addr", 32'(bus.v_ada), 32'(e.addr));
          chk("wr_data", 32'(bus.v_din), 32'(e.data));
          chk("wr_done", 32'(bus.clr_done), 32'(e.done));
          if (e.done) chk("busy_at_done", 32'(bus.clr_busy), 32'd1);
        end
      end else if (bus.clr_done) begin
        chk("done_without_write", 32'(bus.clr_done), 32'd0);
      end
      prev_done <= bus.clr_done;
    end else begin
      prev_done <= 1'b0;
    end
  end

  task automatic chk_reset_vals();
    chk("rst_v_ada",   32'(bus.v_ada), 32'd0);
    chk("rst_v_din",   32'(bus.v_din), 32'd0);
    chk("rst_v_cea",   32'(bus.v_cea), 32'd0);
    chk("rst_pins",    32'({bus.v_reseta, bus.v_resetb, bus.v_ceb, bus.v_oce}), 32'b0011);
    chk("rst_done",    32'(bus.clr_done), 32'd0);
    chk("rst_readys",  32'({bus.req0_ready, bus.req1_ready}), 32'd0);
    chk("rst_busy",    32'(bus.clr_busy), 32'd1);
  endtask

  initial begin
    logic prev_wr;
    tbl[0] = '{1'b1, 10'h005, 8'h41, 1'b0, 10'h3aa, 8'hee, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 10'h155, 8'h99, 1'b1, 10'h010, 8'h42, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 10'h2aa, 8'h77, 1'b0, 10'h0ff, 8'h66, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 10'h020, 8'h50, 1'b1, 10'h021, 8'h51, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 10'h022, 8'h52, 1'b1, 10'h023, 8'h53, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 10'h024, 8'h54, 1'b1, 10'h025, 8'h55, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 10'h026, 8'h56, 1'b1, 10'h027, 8'h57, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 10'h3ff, 8'h00, 1'b1, 10'h030, 8'h60, 1'b0, 1'b1};
    tbl[8] = '{1'b1, 10'h031, 8'h61, 1'b0, 10'h111, 8'h11, 1'b1, 1'b0};
    tbl[9] = '{1'b1, 10'h032, 8'h62, 1'b1, 10'h033, 8'h63, 1'b0, 1'b1};

    // Reset with everything asserted: nothing may leak through.
    rst_n = 1'b0;
    bus.clr_start = 1'b1; bus.clr_char = 8'hab;
    bus.req0_valid = 1'b1; bus.req0_addr = 10'h001; bus.req0_data = 8'h01;
    bus.req1_valid = 1'b1; bus.req1_addr = 10'h002; bus.req1_data = 8'h02;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    bus.clr_start = 1'b0; bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    push_clear(8'h20);
    rst_n = 1'b1;
    wait_clear();

    // Arbitration table; each step expects a write on the following cycle.
    prev_wr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      bus.req0_valid = tbl[i].v0; bus.req0_addr = tbl[i].a0; bus.req0_data = tbl[i].d0;
      bus.req1_valid = tbl[i].v1; bus.req1_addr = tbl[i].a1; bus.req1_data = tbl[i].d1;
      @(negedge clk);
      chk($sformatf("ready0_step%0d", i), 32'(bus.req0_ready), 32'(tbl[i].r0));
      chk($sformatf("ready1_step%0d", i), 32'(bus.req1_ready), 32'(tbl[i].r1));
      if (prev_wr) chk($sformatf("b2b_cea_step%0d", i), 32'(bus.v_cea), 32'd1);
      if (tbl[i].r0)      sb.push_back('{tbl[i].a0, tbl[i].d0, 1'b0});
      else if (tbl[i].r1) sb.push_back('{tbl[i].a1, tbl[i].d1, 1'b0});
      prev_wr = tbl[i].r0 | tbl[i].r1;
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    @(negedge clk);
    chk("last_write_cea", 32'(bus.v_cea), 32'd1);
    @(negedge clk);
    chk("idle_cea", 32'(bus.v_cea), 32'd0);
    chk("arb_drained", 32'(sb.size()), 32'd0);

    // Requested clear beats a simultaneous request; restart attempt mid-clear is ignored.
    @(posedge clk); #1;
    bus.clr_start = 1'b1; bus.clr_char = 8'h2e;
    bus.req1_valid = 1'b1; bus.req1_addr = 10'h100; bus.req1_data = 8'hcc;
    @(negedge clk);
    chk("clr_start_r1", 32'(bus.req1_ready), 32'd0);
    chk("clr_start_r0", 32'(bus.req0_ready), 32'd0);
    push_clear(8'h2e);
    @(posedge clk); #1;
    bus.clr_start = 1'b0; bus.clr_char = 8'hff;
    @(negedge clk);
    chk("clr_busy_started", 32'(bus.clr_busy), 32'd1);
    wait_addr(10'd500);
    @(posedge clk); #1;
    bus.clr_start = 1'b1; bus.clr_char = 8'h55; bus.req1_valid = 1'b0;
    @(posedge clk); #1;
    bus.clr_start = 1'b0;
    wait_clear();

    // Reset in the middle of a clear; the automatic clear restarts from 0.
    @(posedge clk); #1;
    bus.clr_start = 1'b1; bus.clr_char = 8'h77;
    @(posedge clk); #1;
    bus.clr_start = 1'b0;
    push_clear(8'h77);
    wait_addr(10'd300);
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    sb.delete();
    repeat (2) @(negedge clk);
    push_clear(8'h20);
    rst_n = 1'b1;
    wait_clear();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/vram_wr_arb.md
VRAM_WR_ARB -- requirements
Module: vram_wr_arb

Parameters
REQ-001 SHALL have parameter INIT_CHAR, default 8'h20, the fill byte for the automatic clear after reset.
REQ-002 SHALL have parameter DEPTH, default 1024, the number of text-VRAM entries; address width is fixed at 10 bits.

Interface
REQ-003 MEMORY_CLK  in  1  clock; every register in the block is clocked on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 clr_start  in  1  single-cycle request to fill all of VRAM with clr_char.
REQ-006 clr_char  in  8  fill byte, sampled only in the cycle clr_start is accepted.
REQ-007 clr_busy  out  1  high while a clear (automatic or requested) is running.
REQ-008 clr_done  out  1  one-cycle pulse marking the final clear write.
REQ-009 req0_valid / req0_addr / req0_data  in  1/10/8  write request from requester 0 (CPU).
REQ-010 req0_ready  out  1  requester 0 is granted this cycle.
REQ-011 req1_valid / req1_addr / req1_data  in  1/10/8  write request from requester 1 (terminal/UART).
REQ-012 req1_ready  out  1  requester 1 is granted this cycle.
REQ-013 v_ada / v_din / v_cea  out  10/8/1  drive the VRAM write port: address, data and write enable.
REQ-014 v_reseta / v_resetb / v_ceb / v_oce  out  1 each  VRAM control pins, held constant at 0/0/1/1.

Function
REQ-015 SHALL implement an FSM with two states, CLEAR and SERVE.
REQ-016 SHALL enter CLEAR on reset release, with clear counter 0 and fill byte INIT_CHAR.
REQ-017 In CLEAR, SHALL drive exactly one registered write per clock, with v_cea=1, v_ada=counter and v_din=fill byte.
REQ-018 In CLEAR, SHALL increment the counter by 1 after each write.
REQ-019 A clear SHALL write addresses 0..DEPTH-1 in order, with no gaps and no repeats.
REQ-020 clr_done SHALL be 1 in exactly the cycle in which v_cea=1 and v_ada=DEPTH-1.
REQ-021 After that cycle, the FSM SHALL go to SERVE and clr_busy SHALL fall on the next edge.
REQ-022 clr_busy SHALL equal (state==CLEAR).
REQ-023 A clr_start while busy SHALL be ignored; it SHALL NOT be queued and SHALL NOT restart the counter.
REQ-024 In SERVE, clr_start=1 SHALL take priority over both requesters: that cycle both readys are 0, the FSM enters CLEAR with counter 0, and clr_char is latched.
REQ-025 The first requested-clear write SHALL appear one edge later.
REQ-026 In CLEAR, req0_ready and req1_ready SHALL both be 0.
REQ-027 In SERVE without clr_start, at most one ready SHALL be asserted, combinationally from the valids and the last_grant register.
REQ-028 If only one requester is valid, that requester SHALL be granted.
REQ-029 If both requesters are valid, the one NOT equal to last_grant SHALL be granted (round-robin).
REQ-030 If neither requester is valid, both readys SHALL be 0 and last_grant SHALL be unchanged.
REQ-031 A transfer SHALL occur when valid&ready; last_grant SHALL then update to the granted index.
REQ-032 On the edge after a transfer, v_cea SHALL be 1 with v_ada/v_din equal to the granted addr/data (one-cycle write latency).
REQ-033 v_cea SHALL be 0 in every cycle without a write; v_ada/v_din SHALL hold their last values.
REQ-034 Sustained throughput SHALL be one write per clock; back-to-back transfers SHALL need no idle cycle.
REQ-035 Requester inputs SHALL be treated as don't-care while valid=0.
REQ-036 A requester may hold valid until ready; the block SHALL NOT require valid to be stable.
REQ-037 The counter SHALL be 10 bits and SHALL NOT wrap past DEPTH-1 during a clear; writes stop at DEPTH-1.

Reset
REQ-038 While rst_n=0, outputs SHALL be: v_ada=0, v_din=0, v_cea=0, v_reseta=0, v_resetb=0, v_ceb=1, v_oce=1, clr_done=0.
REQ-039 While rst_n=0, readys SHALL be 0, clr_busy SHALL be 1 and last_grant SHALL be 1, so requester 0 wins the first tie.
REQ-040 Asserting rst_n mid-clear or mid-transfer SHALL immediately force the REQ-038/039 values; no partial write is completed.
REQ-041 After reset release, the automatic clear SHALL restart from address 0.

Verification
REQ-042 Bench SHALL cover: release reset, no requests -> 1024 consecutive cycles of v_cea=1, v_ada 0..1023, v_din=0x20; clr_done with v_ada=0x3FF; clr_busy falls on the next edge.
REQ-043 Bench SHALL cover: SERVE, req0 held valid (addr 0x005, data 0x41), req1 idle -> req0_ready=1 that cycle; next edge v_cea=1, v_ada=0x005, v_din=0x41.
REQ-044 Bench SHALL cover: both valid for 4 cycles -> grants 0,1,0,1; readys never both 1; four back-to-back v_cea cycles.
REQ-045 Bench SHALL cover: SERVE, clr_start=1 with clr_char=0x2E and req1_valid=1 in the same cycle -> req1_ready=0; 1024 writes of 0x2E follow; a second clr_start at write 500 has no effect.
REQ-046 Bench SHALL cover: rst_n pulled low at clear address 300 -> v_cea=0 immediately; after release, clear restarts at address 0 with 0x20.
REQ-047 Bench SHALL cover: req1 transfer, then only req0 valid -> req0 granted immediately (no starvation when idle); last_grant=0 afterwards.
